// File: rtl/ball_motion.sv
// Per-ball motion engine: integrates fixed-point velocity once per frame,
// reflects off the table rails, and applies periodic friction until rest.
module ball_motion #(
   parameter int INIT_X        = 100,
   parameter int INIT_Y        = 200,
   parameter int X_MIN         = 32,
   parameter int X_MAX         = 592,
   parameter int Y_MIN         = 32,
   parameter int Y_MAX         = 432,
   parameter int FRICTION_DIV  = 4,
   parameter int FRICTION_STEP = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               collisionOccurred,
   input  logic signed [10:0] ballVelXIn,
   input  logic signed [10:0] ballVelYIn,
   input  logic               cueHit,
   input  logic signed [10:0] cueVelX,
   input  logic signed [10:0] cueVelY,
   output logic signed [10:0] ballTopLeftPosX,
   output logic signed [10:0] ballTopLeftPosY,
   output logic signed [10:0] ballVelX,
   output logic signed [10:0] ballVelY,
   output logic               moving,
   output logic               stopped
);

   typedef enum logic [1:0] {IDLE, MOVING, STEP, DECAY} state_t;

   typedef struct packed {
      logic signed [16:0] pos;
      logic signed [10:0] vel;
   } axis_t;

   localparam logic [3:0]         CNT_LAST = 4'(FRICTION_DIV - 1);
   localparam logic signed [11:0] FSTEP    = 12'(FRICTION_STEP);

   state_t             state_q, state_d;
   logic signed [16:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic signed [10:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               moving_q, moving_d;
   logic               stopped_q, stopped_d;

   // Negation that cannot wrap: -(-1024) saturates to +1023.
   function automatic logic signed [10:0] neg_sat(input logic signed [10:0] v);
      return (v == -11'sd1024) ? 11'sd1023 : -v;
   endfunction

   function automatic logic signed [10:0] fric(input logic signed [10:0] v);
      logic signed [11:0] w;
      logic signed [11:0] r;
      w = {v[10], v};
      if (w > FSTEP)       r = w - FSTEP;
      else if (w < -FSTEP) r = w + FSTEP;
      else                 r = 12'sd0;
      return r[10:0];
   endfunction

   function automatic axis_t wall(input axis_t a, input int lo, input int hi);
      axis_t              r;
      logic signed [10:0] ip;
      r  = a;
      ip = a.pos[16:6];
      if (ip < lo) begin
         r.pos = {11'(lo), 6'd0};
         r.vel = neg_sat(a.vel);
      end else if (ip > hi) begin
         r.pos = {11'(hi), 6'd0};
         r.vel = neg_sat(a.vel);
      end
      return r;
   endfunction

   always_comb begin
      axis_t      ax;
      axis_t      ay;
      logic [3:0] cnt_n;
      state_d   = state_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      vel_x_d   = vel_x_q;
      vel_y_d   = vel_y_q;
      cnt_d     = cnt_q;
      stopped_d = 1'b0;
      ax        = '0;
      ay        = '0;
      cnt_n     = '0;
      // Loads pre-empt any frame update, including a coincident startOfFrame.
      if (collisionOccurred || cueHit) begin
         vel_x_d = collisionOccurred ? ballVelXIn : cueVelX;
         vel_y_d = collisionOccurred ? ballVelYIn : cueVelY;
         cnt_d   = '0;
         state_d = (vel_x_d != 0 || vel_y_d != 0) ? MOVING : IDLE;
      end else begin
         case (state_q)
            IDLE:   state_d = IDLE;
            MOVING: if (startOfFrame) state_d = STEP;
            STEP: begin
               pos_x_d = pos_x_q + {{6{vel_x_q[10]}}, vel_x_q};
               pos_y_d = pos_y_q + {{6{vel_y_q[10]}}, vel_y_q};
               state_d = DECAY;
            end
            DECAY: begin
               ax    = wall('{pos: pos_x_q, vel: vel_x_q}, X_MIN, X_MAX);
               ay    = wall('{pos: pos_y_q, vel: vel_y_q}, Y_MIN, Y_MAX);
               cnt_n = (cnt_q >= CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
               if (cnt_n == 4'd0) begin
                  ax.vel = fric(ax.vel);
                  ay.vel = fric(ay.vel);
               end
               pos_x_d = ax.pos;
               pos_y_d = ay.pos;
               vel_x_d = ax.vel;
               vel_y_d = ay.vel;
               cnt_d   = cnt_n;
               if (ax.vel == 0 && ay.vel == 0) begin
                  state_d   = IDLE;
                  stopped_d = 1'b1;
               end else begin
                  state_d = MOVING;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      moving_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pos_x_q   <= {11'(INIT_X), 6'd0};
         pos_y_q   <= {11'(INIT_Y), 6'd0};
         vel_x_q   <= '0;
         vel_y_q   <= '0;
         cnt_q     <= '0;
         moving_q  <= 1'b0;
         stopped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         vel_x_q   <= vel_x_d;
         vel_y_q   <= vel_y_d;
         cnt_q     <= cnt_d;
         moving_q  <= moving_d;
         stopped_q <= stopped_d;
      end
   end

   assign ballTopLeftPosX = pos_x_q[16:6];
   assign ballTopLeftPosY = pos_y_q[16:6];
   assign ballVelX        = vel_x_q;
   assign ballVelY        = vel_y_q;
   assign moving          = moving_q;
   assign stopped         = stopped_q;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: three instances (default, per-frame
// friction, and one parked beside the rails) with hand-computed expectations.
module tb_ball_motion;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst [3];
   logic               sof [3];
   logic               col [3];
   logic               cue [3];
   logic signed [10:0] cvx [3], cvy [3], kvx [3], kvy [3];
   logic signed [10:0] px [3], py [3], vx [3], vy [3];
   logic               mv [3], st [3];

   ball_motion u_dut_a (
      .clk(clk), .reset(rst[0]), .startOfFrame(sof[0]), .collisionOccurred(col[0]),
      .ballVelXIn(cvx[0]), .ballVelYIn(cvy[0]), .cueHit(cue[0]), .cueVelX(kvx[0]), .cueVelY(kvy[0]),
      .ballTopLeftPosX(px[0]), .ballTopLeftPosY(py[0]), .ballVelX(vx[0]), .ballVelY(vy[0]),
      .moving(mv[0]), .stopped(st[0]));

   ball_motion #(.FRICTION_DIV(1)) u_dut_b (
      .clk(clk), .reset(rst[1]), .startOfFrame(sof[1]), .collisionOccurred(col[1]),
      .ballVelXIn(cvx[1]), .ballVelYIn(cvy[1]), .cueHit(cue[1]), .cueVelX(kvx[1]), .cueVelY(kvy[1]),
      .ballTopLeftPosX(px[1]), .ballTopLeftPosY(py[1]), .ballVelX(vx[1]), .ballVelY(vy[1]),
      .moving(mv[1]), .stopped(st[1]));

   ball_motion #(.INIT_X(591), .INIT_Y(33)) u_dut_c (
      .clk(clk), .reset(rst[2]), .startOfFrame(sof[2]), .collisionOccurred(col[2]),
      .ballVelXIn(cvx[2]), .ballVelYIn(cvy[2]), .cueHit(cue[2]), .cueVelX(kvx[2]), .cueVelY(kvy[2]),
      .ballTopLeftPosX(px[2]), .ballTopLeftPosY(py[2]), .ballVelX(vx[2]), .ballVelY(vy[2]),
      .moving(mv[2]), .stopped(st[2]));

   typedef struct {
      int                 due;
      int                 dut;
      string              name;
      logic signed [10:0] px, py, vx, vy;
      logic               mv, st;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   stop_cnt [3] = '{0, 0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops every expectation whose due cycle has arrived.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) if (st[i] === 1'b1) stop_cnt[i]++;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         exp_t e;
         int   d;
         e = exp_q.pop_front();
         d = e.dut;
         checks++;
         if (e.due != cyc || px[d] !== e.px || py[d] !== e.py || vx[d] !== e.vx ||
             vy[d] !== e.vy || mv[d] !== e.mv || st[d] !== e.st) begin
            errors++;
            $display("FAIL %s dut%0d cyc%0d: got pos=(%0d,%0d) vel=(%0d,%0d) mv=%0b st=%0b, want pos=(%0d,%0d) vel=(%0d,%0d) mv=%0b st=%0b",
                     e.name, d, cyc, px[d], py[d], vx[d], vy[d], mv[d], st[d],
                     e.px, e.py, e.vx, e.vy, e.mv, e.st);
         end else begin
            $display("ok   %s dut%0d cyc%0d pos=(%0d,%0d) vel=(%0d,%0d) mv=%0b st=%0b",
                     e.name, d, cyc, px[d], py[d], vx[d], vy[d], mv[d], st[d]);
         end
      end
   end

   task automatic expect_at(input int d, input int lat, input string nm,
                            input int epx, input int epy, input int evx, input int evy,
                            input bit emv, input bit est);
      exp_t e;
      e.due = cyc + lat; e.dut = d; e.name = nm;
      e.px = 11'(epx); e.py = 11'(epy); e.vx = 11'(evx); e.vy = 11'(evy);
      e.mv = emv; e.st = est;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle pulse on dut d; returns just after the edge that sampled it.
   task automatic drive(input int d, input bit s, input bit c, input int cx, input int cy,
                        input bit k, input int kx, input int ky);
      sof[d] = s; col[d] = c; cvx[d] = 11'(cx); cvy[d] = 11'(cy);
      cue[d] = k; kvx[d] = 11'(kx); kvy[d] = 11'(ky);
      wait_cyc(1);
      sof[d] = 1'b0; col[d] = 1'b0; cue[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; sof[i] = 1'b0; col[i] = 1'b0; cue[i] = 1'b0;
         cvx[i] = '0; cvy[i] = '0; kvx[i] = '0; kvy[i] = '0;
      end
      @(posedge clk); #1;
      wait_cyc(2);
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      expect_at(0, 0, "reset_a", 100, 200, 0, 0, 0, 0);
      expect_at(1, 0, "reset_b", 100, 200, 0, 0, 0, 0);
      expect_at(2, 0, "reset_c", 591, 33, 0, 0, 0, 0);
      wait_cyc(1);

      // Idle ball ignores frames.
      for (int f = 0; f < 3; f++) begin
         drive(0, 1, 0, 0, 0, 0, 0, 0);
         expect_at(0, 0, "idle_sof", 100, 200, 0, 0, 0, 0);
         expect_at(0, 2, "idle_sof_late", 100, 200, 0, 0, 0, 0);
         wait_cyc(3);
      end

      // Cue strike and one frame step.
      drive(0, 0, 0, 0, 0, 1, 64, -128);
      expect_at(0, 0, "cue_load", 100, 200, 64, -128, 1, 0);
      wait_cyc(1);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      expect_at(0, 1, "cue_step", 101, 198, 64, -128, 1, 0);
      expect_at(0, 2, "cue_decay", 101, 198, 64, -128, 1, 0);
      wait_cyc(3);

      // Collision beats cue; coincident frame is dropped.
      drive(0, 1, 1, -64, 32, 1, 500, 500);
      expect_at(0, 0, "coll_load", 101, 198, -64, 32, 1, 0);
      expect_at(0, 1, "coll_nostep1", 101, 198, -64, 32, 1, 0);
      expect_at(0, 2, "coll_nostep2", 101, 198, -64, 32, 1, 0);
      wait_cyc(3);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      expect_at(0, 1, "coll_step", 100, 198, -64, 32, 1, 0);
      expect_at(0, 2, "coll_decay", 100, 198, -64, 32, 1, 0);
      wait_cyc(3);

      // Reset landing on the DECAY cycle, with a load alongside it.
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      expect_at(0, 1, "pre_rst_step", 99, 199, -64, 32, 1, 0);
      wait_cyc(1);
      rst[0] = 1'b1; col[0] = 1'b1; cvx[0] = 11'sd100; cvy[0] = 11'sd100;
      wait_cyc(1);
      rst[0] = 1'b0; col[0] = 1'b0;
      expect_at(0, 0, "rst_in_decay", 100, 200, 0, 0, 0, 0);
      wait_cyc(1);

      // Zero-velocity load goes straight to IDLE without a stopped pulse.
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      expect_at(0, 0, "zero_cue", 100, 200, 0, 0, 0, 0);
      wait_cyc(2);

      // Per-frame friction brings the ball to rest.
      drive(1, 0, 0, 0, 0, 1, 2, 0);
      expect_at(1, 0, "fric_load", 100, 200, 2, 0, 1, 0);
      wait_cyc(1);
      drive(1, 1, 0, 0, 0, 0, 0, 0);
      expect_at(1, 1, "fric_step1", 100, 200, 2, 0, 1, 0);
      expect_at(1, 2, "fric_decay1", 100, 200, 1, 0, 1, 0);
      wait_cyc(3);
      drive(1, 1, 0, 0, 0, 0, 0, 0);
      expect_at(1, 2, "fric_stop", 100, 200, 0, 0, 0, 1);
      expect_at(1, 3, "fric_after", 100, 200, 0, 0, 0, 0);
      wait_cyc(4);

      // Right rail clamp and reflection.
      drive(2, 0, 0, 0, 0, 1, 128, 0);
      expect_at(2, 0, "wallx_load", 591, 33, 128, 0, 1, 0);
      wait_cyc(1);
      drive(2, 1, 0, 0, 0, 0, 0, 0);
      expect_at(2, 1, "wallx_step", 593, 33, 128, 0, 1, 0);
      expect_at(2, 2, "wallx_reflect", 592, 33, -128, 0, 1, 0);
      wait_cyc(3);

      // Top rail with saturating negation of -1024.
      drive(2, 0, 0, 0, 0, 1, 0, -1024);
      expect_at(2, 0, "wally_load", 592, 33, 0, -1024, 1, 0);
      wait_cyc(1);
      drive(2, 1, 0, 0, 0, 0, 0, 0);
      expect_at(2, 1, "wally_step", 592, 17, 0, -1024, 1, 0);
      expect_at(2, 2, "wally_sat", 592, 32, 0, 1023, 1, 0);
      wait_cyc(3);

      for (int n = 0; n < 50 && exp_q.size() > 0; n++) wait_cyc(1);
      if (exp_q.size() > 0) begin
         checks++; errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      for (int i = 0; i < 3; i++) begin
         int want;
         want = (i == 1) ? 1 : 0;
         checks++;
         if (stop_cnt[i] != want) begin
            errors++;
            $display("FAIL stop_count dut%0d: got %0d, want %0d", i, stop_cnt[i], want);
         end else begin
            $display("ok   stop_count dut%0d = %0d", i, stop_cnt[i]);
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ball_motion.md
BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 Parameter INIT_X, default 100: reset top-left X, pixels.
REQ-002 Parameter INIT_Y, default 200: reset top-left Y, pixels.
REQ-003 Parameter X_MIN / X_MAX, default 32 / 592: legal top-left X range, inclusive.
REQ-004 Parameter Y_MIN / Y_MAX, default 32 / 432: legal top-left Y range, inclusive.
REQ-005 Parameter FRICTION_DIV, default 4: frames between friction decrements, range 1..15.
REQ-006 Parameter FRICTION_STEP, default 1: magnitude decrement per friction event, in 1/64 px/frame.
REQ-007 clk  in  1: single clock; all state changes on its rising edge.
REQ-008 reset  in  1: synchronous, active-high reset.
REQ-009 startOfFrame  in  1: one-cycle pulse, once per video frame.
REQ-010 collisionOccurred  in  1: one-cycle pulse from the ball-collision stage; load collision velocity.
REQ-011 ballVelXIn / ballVelYIn  in  11 signed: post-collision velocity, 1/64 px/frame.
REQ-012 cueHit  in  1: one-cycle pulse; load cue velocity.
REQ-013 cueVelX / cueVelY  in  11 signed: cue strike velocity, 1/64 px/frame.
REQ-014 ballTopLeftPosX / ballTopLeftPosY  out  11 signed: integer pixel position.
REQ-015 ballVelX / ballVelY  out  11 signed: current velocity; feeds the ball-collision stage.
REQ-016 moving  out  1: high while in MOVING, STEP or DECAY.
REQ-017 stopped  out  1: one-cycle pulse when the ball comes to rest.

Function
REQ-018 Position SHALL be held as 17-bit signed fixed point (11 integer, 6 fraction); ballTopLeftPos SHALL be its integer part (truncation toward minus infinity).
REQ-019 FSM states SHALL be IDLE, MOVING, STEP, DECAY; all outputs registered.
REQ-020 IDLE: velocity zero; startOfFrame ignored.
REQ-021 MOVING + startOfFrame -> STEP; otherwise remain.
REQ-022 STEP (1 cycle): pos <= pos + sign-extended velocity; -> DECAY.
REQ-023 DECAY (1 cycle), wall rule per axis: if integer pos < MIN, pos <= MIN.0 and vel <= -vel; if > MAX, pos <= MAX.0 and vel <= -vel.
REQ-024 DECAY friction: frameCnt increments mod FRICTION_DIV; on wrap to 0, each nonzero component moves FRICTION_STEP toward zero, clamped at 0 without crossing sign.
REQ-025 Wall negation SHALL be applied before friction in the same DECAY cycle; -(-1024) SHALL saturate to +1023.
REQ-026 DECAY -> IDLE with stopped=1 for one cycle if both resulting components are zero; else -> MOVING.
REQ-027 Load priority: collisionOccurred > cueHit > FSM update; a load is accepted in any state.
REQ-028 On load: velocity <= selected input, frameCnt <= 0; next state MOVING if either component nonzero, else IDLE (no stopped pulse); a STEP/DECAY in progress is abandoned, and any position already written is kept.
REQ-029 startOfFrame coincident with a load SHALL be ignored for that frame.
REQ-030 Latency: position reflects a frame step 1 cycle after startOfFrame; wall and friction results appear 2 cycles after it.

Reset
REQ-031 On reset: pos = INIT_X.0 / INIT_Y.0, velocity 0, frameCnt 0, state IDLE, moving 0, stopped 0.
REQ-032 Reset SHALL override all loads and pulses in the same cycle, including reset asserted mid-STEP or mid-DECAY.

Verification
REQ-033 Reset, then startOfFrame x3 -> position stays (100,200); moving=0; no stopped pulse.
REQ-034 cueHit vel (64,-128), one frame -> position (101,198) two cycles after startOfFrame; moving=1.
REQ-035 Ball at X=591, vel X=+128, frame -> X=592 with vel X=-128 (clamped and reflected); Y unaffected.
REQ-036 cueHit vel (2,0), FRICTION_DIV=1 -> vel X 2->1->0 over two frames; stopped pulses once; state IDLE.
REQ-037 collisionOccurred and cueHit in the same cycle as startOfFrame -> collision velocity loaded, no position step that frame.
REQ-038 Reset asserted in the DECAY cycle -> next cycle pos=(100,200), vel 0, moving=0, stopped=0.
